decoder_seq: RTL and testbench

DECODER_SEQ -- requirements
Module: decoder_seq

---
 rtl/decoder_seq.sv | 149 ++++++++++++++
 tb/tb_decoder_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/decoder_seq.sv
// Registered one-hot LED decoder with direct, scan-up, scan-down and hold modes.
// Optional ping-pong scanning is enabled by defining DECODER_SEQ_BOUNCE_EN.
module decoder_seq #(
  parameter int SEL_W      = 3,
  parameter int DIV_MAX    = 12_499_999,
  parameter int DIV_W      = 24,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            enable,
  input  logic [SEL_W-1:0]      switch,
  input  logic [1:0]            mode,
  output logic [2**SEL_W-1:0]   led,
  output logic [SEL_W-1:0]      pos,
  output logic                  wrap
);

  localparam int OUT_W = 2**SEL_W;
  localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(DIV_MAX);
  localparam logic [SEL_W-1:0] POS_MAX  = SEL_W'(OUT_W - 1);
  localparam logic [OUT_W-1:0] INACTIVE = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    M_DIRECT = 2'b00,
    M_UP     = 2'b01,
    M_DOWN   = 2'b10,
    M_HOLD   = 2'b11
  } mode_t;

  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] p);
    logic [OUT_W-1:0] oh;
    oh    = '0;
    oh[p] = 1'b1;
    return (ACTIVE_LOW != 0) ? ~oh : oh;
  endfunction

  // Input sample stage; mode_p holds the previous sample for change detection.
  logic [2:0]       en_s;
  logic [SEL_W-1:0] sw_s;
  mode_t            mode_s;
  mode_t            mode_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_s   <= 3'b000;
      sw_s   <= '0;
      mode_s <= M_DIRECT;
      mode_p <= M_DIRECT;
    end else begin
      en_s   <= enable;
      sw_s   <= switch;
      mode_s <= mode_t'(mode);
      mode_p <= mode_s;
    end
  end

  logic [DIV_W-1:0] presc;
  logic [DIV_W-1:0] presc_n;
  logic [SEL_W-1:0] pos_n;
  logic             wrap_n;
  logic             active;
  logic             mode_chg;
  logic             scan;
  logic             tick;

`ifdef DECODER_SEQ_BOUNCE_EN
  logic dir;    // 0 = counting up, 1 = counting down
  logic dir_n;
`endif

  always_comb begin
    pos_n    = pos;
    presc_n  = presc;
    wrap_n   = 1'b0;
    active   = (en_s == 3'b100);
    mode_chg = (mode_s != mode_p);
    scan     = (mode_s == M_UP) || (mode_s == M_DOWN);
    tick     = (presc == DIV_TC);
`ifdef DECODER_SEQ_BOUNCE_EN
    dir_n    = dir;
    if (mode_chg && mode_s == M_UP)   dir_n = 1'b0;
    if (mode_chg && mode_s == M_DOWN) dir_n = 1'b1;
`endif
    // A mode change restarts the prescaler but keeps the current index.
    if (mode_chg) presc_n = '0;
    if (active) begin
      if (mode_s == M_DIRECT) begin
        pos_n = sw_s;
      end else if (scan && !mode_chg) begin
        if (!tick) begin
          presc_n = presc + DIV_W'(1);
        end else begin
          presc_n = '0;
`ifdef DECODER_SEQ_BOUNCE_EN
          if (!dir) begin
            if (pos == POS_MAX) begin
              dir_n  = 1'b1;
              pos_n  = pos - SEL_W'(1);
              wrap_n = 1'b1;
            end else begin
              pos_n = pos + SEL_W'(1);
            end
          end else begin
            if (pos == '0) begin
              dir_n  = 1'b0;
              pos_n  = pos + SEL_W'(1);
              wrap_n = 1'b1;
            end else begin
              pos_n = pos - SEL_W'(1);
            end
          end
`else
          if (mode_s == M_UP) begin
            pos_n  = pos + SEL_W'(1);
            wrap_n = (pos == POS_MAX);
          end else begin
            pos_n  = pos - SEL_W'(1);
            wrap_n = (pos == '0);
          end
`endif
        end
      end
    end
  end

  // Output stage: led is always decoded from the same next index loaded into pos.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos   <= '0;
      presc <= '0;
      wrap  <= 1'b0;
      led   <= INACTIVE;
    end else begin
      pos   <= pos_n;
      presc <= presc_n;
      wrap  <= wrap_n;
      led   <= active ? decode(pos_n) : INACTIVE;
    end
  end

`ifdef DECODER_SEQ_BOUNCE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dir <= 1'b0;
    else     dir <= dir_n;
  end
`endif

endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq with SEL_W=3, DIV_MAX=3, ACTIVE_LOW=1.
module tb_decoder_seq;

  logic       clk;
  logic       rst;
  logic [2:0] enable;
  logic [2:0] switch;
  logic [1:0] mode;
  logic [7:0] led;
  logic [2:0] pos;
  logic       wrap;

  int checks   = 0;
  int failures = 0;

`ifdef DECODER_SEQ_BOUNCE_EN
  localparam logic [2:0] UP_POS2   = 3'd6;
  localparam logic [2:0] UP_POS3   = 3'd5;
  localparam logic [2:0] DOWN_POS2 = 3'd1;
`else
  localparam logic [2:0] UP_POS2   = 3'd0;
  localparam logic [2:0] UP_POS3   = 3'd1;
  localparam logic [2:0] DOWN_POS2 = 3'd7;
`endif

  decoder_seq #(
    .SEL_W(3),
    .DIV_MAX(3),
    .DIV_W(4),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .switch(switch),
    .mode(mode),
    .led(led),
    .pos(pos),
    .wrap(wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] dec(input logic [2:0] p);
    logic [7:0] oh;
    oh    = 8'h00;
    oh[p] = 1'b1;
    return ~oh;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst    = 1'b1;
    enable = 3'b100;
    mode   = 2'b00;
    switch = 3'd5;
    #1;
    chk("reset_led", led, 8'hFF);
    chk("reset_pos", pos, 0);
    chk("reset_wrap", wrap, 0);
    step(2);
    rst = 1'b0;

    // Direct mode: first edge samples, second edge updates outputs.
    step(1);
    chk("first_edge_led", led, 8'hFF);
    chk("first_edge_pos", pos, 0);
    step(1);
    chk("direct_led", led, 8'b11011111);
    chk("direct_pos", pos, 5);
    chk("direct_wrap", wrap, 0);
    step(3);
    chk("direct_hold_pos", pos, 5);
    chk("direct_hold_wrap", wrap, 0);

    // Disable with switch cycling.
    enable = 3'b000;
    for (int i = 0; i < 8; i++) begin
      switch = 3'(i);
      step(1);
      if (i >= 1) begin
        chk("disabled_led", led, 8'hFF);
        chk("disabled_pos", pos, 5);
        chk("disabled_wrap", wrap, 0);
      end
    end
    switch = 3'd5;
    enable = 3'b100;
    step(1);
    chk("reenable_delay_led", led, 8'hFF);
    step(1);
    chk("reenable_led", led, dec(3'd5));
    chk("reenable_pos", pos, 5);

    // Scan up from 6.
    switch = 3'd6;
    step(2);
    chk("preload6_pos", pos, 6);
    mode = 2'b01;
    step(2);
    chk("up_start_pos", pos, 6);
    step(3);
    chk("up_before_tick_pos", pos, 6);
    step(1);
    chk("up_tick1_pos", pos, 7);
    chk("up_tick1_wrap", wrap, 0);
    step(3);
    chk("up_wait_pos", pos, 7);
    chk("up_wait_wrap", wrap, 0);
    step(1);
    chk("up_tick2_pos", pos, UP_POS2);
    chk("up_tick2_wrap", wrap, 1);
    chk("up_tick2_led", led, dec(UP_POS2));
    step(1);
    chk("up_wrap_single", wrap, 0);
    step(2);
    chk("up_wrap_quiet", wrap, 0);
    step(1);
    chk("up_tick3_pos", pos, UP_POS3);
    chk("up_tick3_wrap", wrap, 0);

    // Scan down from 1, then hold.
    switch = 3'd1;
    mode   = 2'b00;
    step(2);
    chk("preload1_pos", pos, 1);
    chk("preload1_led", led, dec(3'd1));
    mode = 2'b10;
    step(2);
    chk("down_start_pos", pos, 1);
    step(4);
    chk("down_tick1_pos", pos, 0);
    chk("down_tick1_wrap", wrap, 0);
    step(4);
    chk("down_tick2_pos", pos, DOWN_POS2);
    chk("down_tick2_wrap", wrap, 1);
    mode = 2'b11;
    step(8);
    chk("hold_pos", pos, DOWN_POS2);
    chk("hold_led", led, dec(DOWN_POS2));
    chk("hold_wrap", wrap, 0);
`ifndef DECODER_SEQ_BOUNCE_EN
    chk("hold_led_const", led, 8'b01111111);
`endif

    // Asynchronous reset in the middle of a scan.
    mode = 2'b01;
    step(3);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_led", led, 8'hFF);
    chk("async_rst_pos", pos, 0);
    chk("async_rst_wrap", wrap, 0);
    #2;
    rst = 1'b0;
    step(5);
    chk("post_rst_pos", pos, 0);
    chk("post_rst_wrap", wrap, 0);
    step(1);
    chk("post_rst_tick_pos", pos, 1);
    chk("post_rst_tick_wrap", wrap, 0);
    chk("post_rst_tick_led", led, dec(3'd1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
